reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port general purpose register file for the RISC-V core: configurable data width, register count and read-port count, two write ports (ALU/writeback and late load/coprocessor return), write-first bypassing and an integrated busy-bit scoreboard for hazard detection. It sits between decode and execute. It supersedes the fixed 32x32b dual-read/single-write file, so the core can retire a load and an ALU result in the same cycle and the image coprocessor can return results into the GPRs.

## Interface
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count (power of two, ≥2); AW = $clog2(NUM_REGS).
- NUM_RP, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero.
- clk  in  1  global clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rd_en  in  NUM_RP  per-port read enable.
- rd_addr  in  NUM_RP×AW  per-port read address.
- rd_data  out  NUM_RP×DATA_W  registered read data.
- rd_busy  out  NUM_RP  registered busy flag for the address read.
- wr_en  in  2  write enables, port 0 = writeback, port 1 = late return.
- wr_addr  in  2×AW  write addresses.
- wr_data  in  2×DATA_W  write data.
- sb_set  in  1  mark register sb_addr busy (instruction issued with that destination).
- sb_addr  in  AW  scoreboard set address.
- any_busy  out  1  registered OR of all busy bits.

## Operation
- Writes: on posedge with wr_en[k] and !rst, reg[wr_addr[k]] <= wr_data[k]. If both ports target the same address in the same cycle, port 1 wins.
- ZERO_REG=1: writes to address 0 are dropped, reads of 0 return 0 and busy 0, and sb_set to 0 is ignored.
- Reads: on posedge with rd_en[i], rd_data[i] and rd_busy[i] load. With rd_en[i]=0, both outputs hold.
- Write-first bypass: a read sampled in the same cycle as a write to the same address returns the new data. If both write ports hit that address, the port-1 value is returned.
- Scoreboard busy bit per register:
  - Any write-port write to a register clears its bit.
  - sb_set sets the bit for sb_addr.
  - sb_set and a write to the same register in the same cycle: set wins, bit ends 1.
- rd_busy[i] reports the busy bit after that cycle's set/clear updates for rd_addr[i].
- Read ports are fully independent. Any number may read the same address.

## Timing
- Read latency: 1 cycle. Address, and write/set sampled at edge N, produce rd_data/rd_busy valid after edge N.
- Write latency: visible to reads sampled at the same edge via bypass, and from array storage thereafter.
- any_busy reflects the busy vector after edge N.
- Reset (rst=1 at edge):
  - All registers, busy bits, rd_data, rd_busy and any_busy go to 0.
  - Writes, sb_set and reads in that cycle are ignored.
  - Reset mid-operation discards pending busy state with no residue.
- No stall or backpressure. Every cycle accepts 2 writes, 1 set and NUM_RP reads.

## Structure
- Add REG_AW/NUM_REGS defaults and a `wr_port_t` struct (en, addr, data) to common_params; DATA_W defaults to BITS.
- Sub-module reg_scoreboard: holds the NUM_REGS busy vector, takes set/clear inputs with set-wins priority, provides the post-update vector and any_busy.
- Top holds the array, write-port priority, the per-port bypass mux (generate loop over NUM_RP), and the output registers.

## Test plan
- Reset, then read all addresses on every port: rd_data=0, rd_busy=0, any_busy=0. Write 0xDEADBEEF to x0, then read x0 → 0.
- Write x5=0x12345678 on port 0 while reading x5 in the same cycle → rd_data=0x12345678 the next cycle. Read again with no write → still 0x12345678.
- Both write ports target x7 (0xAAAA0000 on port 0, 0x5555FFFF on port 1) with a same-cycle read of x7 → rd_data=0x5555FFFF, and stored value 0x5555FFFF.
- sb_set x3 → rd_busy=1, any_busy=1. Write x3 on port 1 → busy 0. Same-cycle sb_set x3 plus write x3 → busy stays 1.
- NUM_RP=4, DATA_W=64, NUM_REGS=16: four ports read x1/x1/x2/x15 concurrently with writes to x2 and x15 → bypassed values on ports 2 and 3, stored value on ports 0 and 1. rd_en low holds the previous outputs.
- Set busy on x4 and write x9=0x1, then assert rst for one cycle mid-stream → x9 reads 0, x4 is not busy, any_busy=0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and types for the multi-port GPR file and its scoreboard.
package reg_file_mp_pkg;
  localparam int BITS         = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW       = $clog2(NUM_REGS_DEF);
  localparam int NUM_WP       = 2;

  // Packed view of one write port at the default geometry.
  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [BITS-1:0]   data;
  } wr_port_t;
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit scoreboard: one bit per register, cleared by writes, set by issue (set wins).
module reg_file_mp_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_i,
  input  logic [AW-1:0]       set_addr_i,
  input  logic [NUM_REGS-1:0] clr_i,
  output logic [NUM_REGS-1:0] busy_next_o,
  output logic                any_busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                any_busy_q;

  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (set_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign busy_next_o = busy_d;
  assign any_busy_o  = any_busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port GPR file: two write ports (port 1 wins), write-first bypass on every
// read port, registered read data/busy, integrated hazard scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = BITS,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RP   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RP-1:0]          rd_en_i,
  input  logic [NUM_RP*AW-1:0]       rd_addr_i,
  output logic [NUM_RP*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RP-1:0]          rd_busy_o,
  input  logic [NUM_WP-1:0]          wr_en_i,
  input  logic [NUM_WP*AW-1:0]       wr_addr_i,
  input  logic [NUM_WP*DATA_W-1:0]   wr_data_i,
  input  logic                       sb_set_i,
  input  logic [AW-1:0]              sb_addr_i,
  output logic                       any_busy_o
);
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_WP-1:0]   we;
  logic [AW-1:0]       wa [NUM_WP];
  logic [DATA_W-1:0]   wd [NUM_WP];
  logic [NUM_REGS-1:0] clr, busy_next;
  logic                set_ok;

  // Writes and sets aimed at a hardwired x0 are squashed here, once, for all consumers.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_WP; k++) begin
      wa[k] = wr_addr_i[k*AW +: AW];
      wd[k] = wr_data_i[k*DATA_W +: DATA_W];
      we[k] = wr_en_i[k] && !(ZERO_REG && (wa[k] == '0));
      if (we[k]) clr[wa[k]] = 1'b1;
    end
    set_ok = sb_set_i && !(ZERO_REG && (sb_addr_i == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WP; k++)
        if (we[k]) mem_q[wa[k]] <= wd[k];
    end
  end

  reg_file_mp_scoreboard #(.NUM_REGS(NUM_REGS), .AW(AW)) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (set_ok),
    .set_addr_i  (sb_addr_i),
    .clr_i       (clr),
    .busy_next_o (busy_next),
    .any_busy_o  (any_busy_o)
  );

  for (genvar i = 0; i < NUM_RP; i++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_busy_d, rd_busy_q;

    assign ra = rd_addr_i[i*AW +: AW];

    always_comb begin
      rd_data_d = mem_q[ra];
      for (int k = 0; k < NUM_WP; k++)
        if (we[k] && (wa[k] == ra)) rd_data_d = wd[k];
      rd_busy_d = busy_next[ra];
      if (ZERO_REG && (ra == '0)) begin
        rd_data_d = '0;
        rd_busy_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_data_q <= '0;
        rd_busy_q <= 1'b0;
      end else if (rd_en_i[i]) begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end

    assign rd_data_o[i*DATA_W +: DATA_W] = rd_data_q;
    assign rd_busy_o[i]                  = rd_busy_q;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp at 64-bit x 16 regs x 4 read ports.
module tb_reg_file_mp;
  localparam int DW = 64;
  localparam int NR = 16;
  localparam int NP = 4;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              any_busy;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers, busy bits and last-latched outputs.
  logic [DW-1:0] m_reg [NR];
  logic          m_busy [NR];
  logic [DW-1:0] m_rd [NP];
  logic          m_rb [NP];
  logic          m_any;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RP(NP), .ZERO_REG(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .sb_set_i   (sb_set),
    .sb_addr_i  (sb_addr),
    .any_busy_o (any_busy)
  );

  task automatic idle();
    rst = 1'b0; rd_en = '0; wr_en = '0; sb_set = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic model_update();
    int a;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
      for (int i = 0; i < NP; i++) begin m_rd[i] = '0; m_rb[i] = 1'b0; end
      m_any = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        a = int'(wr_addr[k*AW +: AW]);
        if (wr_en[k] && a != 0) begin m_reg[a] = wr_data[k*DW +: DW]; m_busy[a] = 1'b0; end
      end
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      for (int i = 0; i < NP; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
        if (rd_en[i]) begin
          m_rd[i] = (a == 0) ? '0 : m_reg[a];
          m_rb[i] = (a == 0) ? 1'b0 : m_busy[a];
        end
      end
      m_any = 1'b0;
      for (int r = 0; r < NR; r++) m_any = m_any | m_busy[r];
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NP; i++) begin
      checks++;
      assert (rd_data[i*DW +: DW] === m_rd[i]) else begin
        errors++;
        $error("FAIL %s rd_data[%0d] got %h exp %h", tag, i, rd_data[i*DW +: DW], m_rd[i]);
      end
      checks++;
      assert (rd_busy[i] === m_rb[i]) else begin
        errors++;
        $error("FAIL %s rd_busy[%0d] got %b exp %b", tag, i, rd_busy[i], m_rb[i]);
      end
    end
    checks++;
    assert (any_busy === m_any) else begin
      errors++;
      $error("FAIL %s any_busy got %b exp %b", tag, any_busy, m_any);
    end
  endtask

  // One clock: inputs already driven; update model at the edge, compare 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
    @(negedge clk);
    idle();
  endtask

  task automatic exp_data(input string tag, input int p, input logic [DW-1:0] v);
    checks++;
    assert (rd_data[p*DW +: DW] === v) else begin
      errors++;
      $error("FAIL %s port%0d data got %h exp %h", tag, p, rd_data[p*DW +: DW], v);
    end
  endtask

  task automatic exp_busy(input string tag, input int p, input logic b, input logic any);
    checks++;
    assert (rd_busy[p] === b && any_busy === any) else begin
      errors++;
      $error("FAIL %s port%0d busy/any got %b/%b exp %b/%b", tag, p, rd_busy[p], any_busy, b, any);
    end
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; sb_addr = '0;
    @(negedge clk);
    rst = 1'b1;
    step("reset");

    for (int a = 0; a < NR; a++) begin
      for (int p = 0; p < NP; p++) rd(p, a);
      step("post_reset_read");
      exp_data("post_reset_zero", 0, '0);
    end

    wr(0, 0, 64'hDEADBEEF);
    step("x0_write");
    rd(0, 0);
    step("x0_read");
    exp_data("x0_zero", 0, '0);

    wr(0, 5, 64'h12345678); rd(1, 5);
    step("x5_bypass");
    exp_data("x5_bypass", 1, 64'h12345678);
    rd(1, 5);
    step("x5_stored");
    exp_data("x5_stored", 1, 64'h12345678);

    wr(0, 7, 64'hAAAA0000); wr(1, 7, 64'h5555FFFF); rd(2, 7);
    step("x7_both");
    exp_data("x7_bypass_p1", 2, 64'h5555FFFF);
    rd(2, 7);
    step("x7_stored");
    exp_data("x7_stored_p1", 2, 64'h5555FFFF);

    sb_set = 1'b1; sb_addr = 4'd3; rd(0, 3);
    step("sb_set_x3");
    exp_busy("x3_set", 0, 1'b1, 1'b1);
    wr(1, 3, 64'h33); rd(0, 3);
    step("x3_clear");
    exp_busy("x3_clear", 0, 1'b0, 1'b0);
    sb_set = 1'b1; sb_addr = 4'd3; wr(0, 3, 64'h44); rd(0, 3);
    step("x3_set_wins");
    exp_busy("x3_set_wins", 0, 1'b1, 1'b1);

    wr(0, 1, 64'h1111_0000_0000_0001); wr(1, 2, 64'h2222);
    step("setup12");
    wr(0, 15, 64'hF0F0);
    step("setup15");
    rd(0, 1); rd(1, 1); rd(2, 2); rd(3, 15);
    wr(0, 2, 64'hBEEF_0002); wr(1, 15, 64'hCAFE_000F);
    step("four_port");
    exp_data("fp_p0_stored", 0, 64'h1111_0000_0000_0001);
    exp_data("fp_p1_stored", 1, 64'h1111_0000_0000_0001);
    exp_data("fp_p2_bypass", 2, 64'hBEEF_0002);
    exp_data("fp_p3_bypass", 3, 64'hCAFE_000F);
    rd_addr = {4'd6, 4'd6, 4'd6, 4'd6}; wr(0, 2, 64'h9999); wr(1, 15, 64'h8888);
    step("rd_en_low");
    exp_data("hold_p2", 2, 64'hBEEF_0002);
    exp_data("hold_p3", 3, 64'hCAFE_000F);

    sb_set = 1'b1; sb_addr = 4'd4; wr(0, 9, 64'h1);
    step("pre_rst");
    rst = 1'b1; rd(0, 9); wr(0, 9, 64'h77); sb_set = 1'b1; sb_addr = 4'd4;
    step("mid_rst");
    rd(0, 9); rd(1, 4);
    step("post_rst");
    exp_data("x9_cleared", 0, '0);
    exp_busy("x4_cleared", 1, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      rd_en = NP'($urandom);
      wr_en = 2'($urandom);
      sb_set = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rd_addr = {NP{AW'($urandom_range(0, 3))}} ^ NP*AW'($urandom & 32'h1111);
        wr_addr = {2{AW'($urandom_range(0, 3))}};
        sb_addr = AW'($urandom_range(0, 3));
      end else begin
        rd_addr = (NP*AW)'($urandom);
        wr_addr = (2*AW)'($urandom);
        sb_addr = AW'($urandom);
      end
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
